// File: rtl/frac_to_bcd_pkg.sv
// Shared fixed-point definitions for the trig CORDIC datapath: Q0.32 widths,
// reference constants and the BCD converter state encoding.
package trig_fixed_pkg;

  localparam int FRAC_W      = 32;
  localparam int BCD_DIGIT_W = 4;

  localparam logic [31:0] PI_4      = 32'hC90FDAA2;
  localparam logic [31:0] INV_SQRT2 = 32'hB504F333;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

endpackage

// File: rtl/frac_to_bcd_if.sv
// Request/result bundle between a fraction producer and the BCD converter.
interface frac_to_bcd_if #(
  parameter int NDIGITS = 8,
  parameter int FRAC_W  = 32
);

  logic                   start;
  logic [FRAC_W-1:0]      frac;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   bcd;

  modport master (output start, frac, input busy, done, bcd);
  modport slave  (input start, frac, output busy, done, bcd);

endinterface

// File: rtl/frac_times10_step.sv
// One decimal digit extraction: multiplies a Q0.W fraction by ten and splits
// the product into its integer digit and the remaining fraction.
module frac_times10_step
  import trig_fixed_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0]       i_acc,
  output logic [BCD_DIGIT_W-1:0] o_digit,
  output logic [ACC_W-1:0]       o_rem
);

  logic [ACC_W+3:0] w_wide;
  logic [ACC_W+3:0] w_prod;

  // x*10 as x*8 + x*2; the integer part can never exceed 9 because x < 1
  assign w_wide  = {4'b0000, i_acc};
  assign w_prod  = (w_wide << 3) + (w_wide << 1);
  assign o_digit = w_prod[ACC_W+3:ACC_W];
  assign o_rem   = w_prod[ACC_W-1:0];

endmodule

// File: rtl/frac_to_bcd.sv
// Sequential Q0.FRAC_W fraction to packed-BCD converter: one truncated decimal
// digit per clock, result published with a one-cycle done pulse.
module frac_to_bcd #(
  parameter int NDIGITS = 8,
  parameter int FRAC_W  = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  frac_to_bcd_if.slave  bus
);

  import trig_fixed_pkg::*;

  localparam int SREG_W = BCD_DIGIT_W * NDIGITS;
  localparam int CNT_W  = (NDIGITS < 2) ? 1 : $clog2(NDIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [FRAC_W-1:0]        r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [SREG_W-1:0]        r_sreg;
  logic [SREG_W-1:0]        r_bcd;
  logic                     r_done;
  logic [SREG_W-1:0]        w_sregNext;
  logic [BCD_DIGIT_W-1:0]   w_digit;
  logic [FRAC_W-1:0]        w_rem;
  logic                     w_accept;
  logic                     w_lastStep;

  frac_times10_step #(
    .ACC_W (FRAC_W)
  ) u_step (
    .i_acc   (r_acc),
    .o_digit (w_digit),
    .o_rem   (w_rem)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // start is only looked at in IDLE, so requests during a conversion are dropped
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_lastStep  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = CONV;
        end
      end
      CONV: begin
        if (r_cnt == LAST_CNT) begin
          w_lastStep  = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  generate
    if (NDIGITS == 1) begin : g_single
      assign w_sregNext = w_digit;
    end else begin : g_multi
      assign w_sregNext = {r_sreg[SREG_W-5:0], w_digit};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sreg <= '0;
      r_bcd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc  <= bus.frac;
        r_cnt  <= '0;
        r_sreg <= '0;
      end else if (r_state == CONV) begin
        r_acc  <= w_rem;
        r_cnt  <= r_cnt + 1'b1;
        r_sreg <= w_sregNext;
        // the final digit is folded straight into the published result
        if (w_lastStep) begin
          r_bcd  <= w_sregNext;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (r_state == CONV);
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_frac_to_bcd.sv
// Directed self-checking bench for frac_to_bcd: table of known fractions plus
// hand-written sequences for streaming start, async abort and a 1-digit build.
module tb_frac_to_bcd;

  typedef struct {
    logic [31:0] frac;
    logic [31:0] expBcd;
  } vec_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  frac_to_bcd_if #(.NDIGITS(8), .FRAC_W(32)) bus8 ();
  frac_to_bcd_if #(.NDIGITS(1), .FRAC_W(32)) bus1 ();

  frac_to_bcd #(.NDIGITS(8), .FRAC_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  frac_to_bcd #(.NDIGITS(1), .FRAC_W(32)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Runs one 8-digit conversion; counts busy cycles, reports the negedge index
  // (after the accept edge) where done appeared and whether bcd held meanwhile.
  task automatic applyStimulus(input logic [31:0] f, output logic [31:0] got,
                               output int busyCycles, output int doneCycle, output bit heldOk);
    logic [31:0] prevBcd;
    @(negedge clk);
    prevBcd        = bus8.bcd;
    bus8.start     = 1'b1;
    bus8.frac      = f;
    @(posedge clk);
    @(negedge clk);
    bus8.start     = 1'b0;
    bus8.frac      = ~f;
    busyCycles     = 0;
    doneCycle      = -1;
    heldOk         = 1'b1;
    got            = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus8.done) begin
        doneCycle = cyc;
        got       = bus8.bcd;
        break;
      end
      if (bus8.busy) busyCycles++;
      if (bus8.bcd !== prevBcd) heldOk = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] got;
    int          busyCycles;
    int          doneCycle;
    bit          heldOk;
    logic [31:0] streamFrac[3];
    logic [31:0] streamExp[3];

    errors = 0;
    checks = 0;

    vecs[0] = '{32'h80000000, 32'h50000000};
    vecs[1] = '{32'hB504F333, 32'h70710678};
    vecs[2] = '{32'hC90FDAA2, 32'h78539816};
    vecs[3] = '{32'hFFFFFFFF, 32'h99999999};
    vecs[4] = '{32'h00000000, 32'h00000000};
    vecs[5] = '{32'h40000000, 32'h25000000};
    vecs[6] = '{32'h1999999A, 32'h10000000};

    streamFrac[0] = 32'h80000000; streamExp[0] = 32'h50000000;
    streamFrac[1] = 32'hB504F333; streamExp[1] = 32'h70710678;
    streamFrac[2] = 32'hC90FDAA2; streamExp[2] = 32'h78539816;

    reset_n    = 1'b0;
    bus8.start = 1'b0;
    bus8.frac  = '0;
    bus1.start = 1'b0;
    bus1.frac  = '0;
    #12;
    checkOutput("reset busy", {31'b0, bus8.busy}, 32'd0);
    checkOutput("reset done", {31'b0, bus8.done}, 32'd0);
    checkOutput("reset bcd", bus8.bcd, 32'd0);
    checkOutput("reset bcd1", {28'b0, bus1.bcd}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] table-driven conversions");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].frac, got, busyCycles, doneCycle, heldOk);
      checkOutput($sformatf("vec%0d bcd", i), got, vecs[i].expBcd);
      checkOutput($sformatf("vec%0d doneCycle", i), doneCycle, 32'd9);
      checkOutput($sformatf("vec%0d busyCycles", i), busyCycles, 32'd8);
      checkOutput($sformatf("vec%0d bcdHeld", i), {31'b0, heldOk}, 32'd1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d doneDrop", i), {31'b0, bus8.done}, 32'd0);
      checkOutput($sformatf("vec%0d bcdKeep", i), bus8.bcd, vecs[i].expBcd);
    end

    $display("[TB] start held high with frac changing every cycle");
    for (int i = 0; i < 27; i++) begin
      bus8.start = 1'b1;
      bus8.frac  = ((i % 9) == 0) ? streamFrac[i / 9] : (32'hDEAD0000 | i);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("stream busy %0d", i), {31'b0, bus8.busy}, {31'b0, ((i % 9) != 8)});
      checkOutput($sformatf("stream done %0d", i), {31'b0, bus8.done}, {31'b0, ((i % 9) == 8)});
      if ((i % 9) == 8) checkOutput($sformatf("stream bcd %0d", i), bus8.bcd, streamExp[i / 9]);
    end
    bus8.start = 1'b0;
    @(negedge clk);
    checkOutput("stream idle", {31'b0, bus8.busy}, 32'd0);

    $display("[TB] asynchronous abort at digit 4");
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.frac  = 32'hC90FDAA2;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'b0, bus8.busy}, 32'd0);
    checkOutput("abort done", {31'b0, bus8.done}, 32'd0);
    checkOutput("abort bcd", bus8.bcd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort noDone %0d", i), {31'b0, bus8.done}, 32'd0);
    end
    applyStimulus(32'h80000000, got, busyCycles, doneCycle, heldOk);
    checkOutput("postAbort bcd", got, 32'h50000000);
    checkOutput("postAbort doneCycle", doneCycle, 32'd9);

    $display("[TB] single-digit build");
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.frac  = 32'h1999999A;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    checkOutput("nd1 busy", {31'b0, bus1.busy}, 32'd1);
    checkOutput("nd1 notDone", {31'b0, bus1.done}, 32'd0);
    @(negedge clk);
    checkOutput("nd1 done", {31'b0, bus1.done}, 32'd1);
    checkOutput("nd1 bcd", {28'b0, bus1.bcd}, 32'h1);
    checkOutput("nd1 idle", {31'b0, bus1.busy}, 32'd0);
    @(negedge clk);
    checkOutput("nd1 doneDrop", {31'b0, bus1.done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
